adder_n: RTL and testbench



---
 rtl/adder_pkg.sv | 12 +
 rtl/full_adder.sv | 24 ++
 rtl/adder_n.sv | 59 +++++
 tb/tb_adder_n.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and defaults for the ripple-carry adder slice.
// Holds the default width and the full-adder result bundle.
package adder_pkg;

  localparam int ADDER_DEFAULT_W = 4;

  typedef struct {
    logic sum;
    logic cout;
  } fa_out_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; one link of the ripple chain.
// Sum and carry are built as a bundle, then split onto ports.
module full_adder
  import adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  fa_out_t r;

  // sum and carry-out of a single bit position
  always_comb begin
    r.sum  = a ^ b ^ ci;
    r.cout = (a & b) | (ci & (a ^ b));
  end

  assign s  = r.sum;
  assign co = r.cout;

endmodule

// File: rtl/adder_n.sv
// N-bit ripple-carry adder with carry and signed overflow.
// Macro ADDER_N_OUTPUT_REG_EN adds a 1-cycle output register.
module adder_n
  import adder_pkg::*;
#(
  parameter int N = ADDER_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] Y,
  output logic         Cout,
  output logic         V,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin
);

  logic [N:0]   c;
  logic [N-1:0] s;
  logic         v_n;

  assign c[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // for N == 1, c[N-1] is Cin itself
  assign v_n = c[N-1] ^ c[N];

`ifdef ADDER_N_OUTPUT_REG_EN
  // capture sum and flags; reset clears them at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y    <= '0;
      Cout <= 1'b0;
      V    <= 1'b0;
    end else begin
      Y    <= s;
      Cout <= c[N];
      V    <= v_n;
    end
  end
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst_n;
  assign Y    = s;
  assign Cout = c[N];
  assign V    = v_n;
`endif

endmodule

// File: tb/tb_adder_n.sv
// Randomised scoreboard bench for adder_n (N = 1, 4, 8, cascade).
// Adapts to ADDER_N_OUTPUT_REG_EN for latency and reset checks.
module tb_adder_n;

`ifdef ADDER_N_OUTPUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0] a4, b4, y4;
  logic       ci4, co4, v4;
  logic       a1, b1, ci1, y1, co1, v1;
  logic [7:0] a8, b8, y8;
  logic       ci8, co8, v8;
  logic [7:0] ca, cb;
  logic [3:0] ly, hy;
  logic       lco, hco, lv, hv;

  always #5 clk = ~clk;

  adder_n #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Y(y4), .Cout(co4), .V(v4),
    .A(a4), .B(b4), .Cin(ci4));

  adder_n #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Y(y1), .Cout(co1), .V(v1),
    .A(a1), .B(b1), .Cin(ci1));

  adder_n #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .Y(y8), .Cout(co8), .V(v8),
    .A(a8), .B(b8), .Cin(ci8));

  adder_n #(.N(4)) lo (
    .clk(clk), .rst_n(rst_n), .Y(ly), .Cout(lco), .V(lv),
    .A(ca[3:0]), .B(cb[3:0]), .Cin(1'b0));

  adder_n #(.N(4)) hi (
    .clk(clk), .rst_n(rst_n), .Y(hy), .Cout(hco), .V(hv),
    .A(ca[7:4]), .B(cb[7:4]), .Cin(lco));

  typedef struct {
    int due;
    int y4; bit co4; bit v4;
    int y1; bit co1; bit v1;
    int y8; bit co8; bit v8;
    bit cas; int cs; bit cv;
  } exp_t;

  exp_t exp_q[$];
  int   cycle = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // reference: plain unsigned sum, overflow from signed range
  function automatic void ref_add(input int n, input int a,
                                  input int b, input int ci,
                                  output int y, output bit co,
                                  output bit v);
    int s, sa, sb, ss;
    s  = a + b + ci;
    y  = s % (1 << n);
    co = (s >> n) != 0;
    sa = (a >= (1 << (n - 1))) ? a - (1 << n) : a;
    sb = (b >= (1 << (n - 1))) ? b - (1 << n) : b;
    ss = sa + sb + ci;
    v  = (ss > (1 << (n - 1)) - 1) || (ss < -(1 << (n - 1)));
  endfunction

  task automatic chk(input string name, input int act,
                     input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                  name, act, req, $time);
  endtask

  task automatic step(input int ta4, input int tb4, input int tc4,
                      input int ta1, input int tb1, input int tc1,
                      input int ta8, input int tb8, input int tc8,
                      input int tca, input int tcb, input bit cas);
    exp_t e;
    int   dy;
    bit   dc;
    @(posedge clk);
    #1;
    a4 = 4'(ta4); b4 = 4'(tb4); ci4 = 1'(tc4);
    a1 = 1'(ta1); b1 = 1'(tb1); ci1 = 1'(tc1);
    a8 = 8'(ta8); b8 = 8'(tb8); ci8 = 1'(tc8);
    ca = 8'(tca); cb = 8'(tcb);
    e.due = cycle + LAT;
    ref_add(4, ta4, tb4, tc4, e.y4, e.co4, e.v4);
    ref_add(1, ta1, tb1, tc1, e.y1, e.co1, e.v1);
    ref_add(8, ta8, tb8, tc8, e.y8, e.co8, e.v8);
    ref_add(8, tca, tcb, 0, dy, dc, e.cv);
    e.cs  = tca + tcb;
    e.cas = cas;
    exp_q.push_back(e);
  endtask

  task automatic rnd_step(input int tca, input int tcb,
                          input bit cas);
    step($urandom_range(15), $urandom_range(15), $urandom_range(1),
         $urandom_range(1), $urandom_range(1), $urandom_range(1),
         $urandom_range(255), $urandom_range(255), $urandom_range(1),
         tca, tcb, cas);
  endtask

  // monitor: compare every entry due this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("due", e.due, cycle);
      chk("y4", int'(y4), e.y4);
      chk("co4", int'(co4), int'(e.co4));
      chk("v4", int'(v4), int'(e.v4));
      chk("y1", int'(y1), e.y1);
      chk("co1", int'(co1), int'(e.co1));
      chk("v1", int'(v1), int'(e.v1));
      chk("y8", int'(y8), e.y8);
      chk("co8", int'(co8), int'(e.co8));
      chk("v8", int'(v8), int'(e.v8));
      if (e.cas) begin
        chk("cas_sum", int'({hco, hy, ly}), e.cs);
        chk("cas_v", int'(hv), int'(e.cv));
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_y4"}, int'(y4), 0);
    chk({tag, "_co4"}, int'(co4), 0);
    chk({tag, "_v4"}, int'(v4), 0);
    chk({tag, "_y8"}, int'(y8), 0);
    chk({tag, "_co8"}, int'(co8), 0);
    chk({tag, "_v8"}, int'(v8), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    a4 = '0; b4 = '0; ci4 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0;
    ca = '0; cb = '0;
    #1 rst_n = 1'b0;
    #1;
`ifdef ADDER_N_OUTPUT_REG_EN
    a8 = 8'd200; b8 = 8'd100; a4 = 4'hF; b4 = 4'h1;
    #1 chk_zero("rst");
`else
    a4 = 4'hF; b4 = 4'h1;
    #1;
    chk("comb_y4", int'(y4), 0);
    chk("comb_co4", int'(co4), 1);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    step(15, 1, 0, 0, 0, 0, 200, 100, 0, 0, 0, 0);
    step(7, 8, 1, 1, 1, 1, 255, 255, 1, 255, 255, LAT == 0);
    step(7, 1, 0, 1, 0, 1, 127, 1, 0, 128, 128, LAT == 0);
    step(15, 15, 1, 0, 1, 0, 128, 128, 0, 127, 1, LAT == 0);
    for (int i = 0; i < 8; i++)
      step($urandom_range(15), $urandom_range(15), 0,
           i & 1, (i >> 1) & 1, (i >> 2) & 1,
           $urandom_range(255), $urandom_range(255), 0,
           0, 0, 0);

`ifdef ADDER_N_OUTPUT_REG_EN
    for (int i = 0; i < 300; i++)
      rnd_step($urandom_range(255), $urandom_range(255), 0);

    @(posedge clk);
    #2;
    a8 = 8'd200; b8 = 8'd100; ci8 = 1'b0;
    a4 = 4'hF; b4 = 4'h1; ci4 = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1 chk_zero("mid_rst");
    @(posedge clk);
    #1 chk_zero("rst_hold");
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk_zero("rel");
    @(posedge clk);
    #1;
    chk("post_y8", int'(y8), 44);
    chk("post_co8", int'(co8), 1);
    chk("post_y4", int'(y4), 0);
    chk("post_co4", int'(co4), 1);
    for (int i = 0; i < 100; i++)
      rnd_step($urandom_range(255), $urandom_range(255), 0);
`else
    for (int a = 0; a < 256; a++)
      for (int b = a; b < 256; b++)
        rnd_step(a, b, 1);
`endif

    repeat (3) @(negedge clk);
    #1 chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
